// File: rtl/multicore_dmem_arbiter.sv
// Round-robin arbiter that serialises per-core load/store requests onto one
// data-memory port and returns a one-cycle acknowledge plus read data.
module multicore_dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  input  logic [NUM_CORES-1:0]          core_rd,
  input  logic [NUM_CORES-1:0]          core_wr,
  output logic [NUM_CORES-1:0]          core_ack,
  output logic [DATA_W-1:0]             core_rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_rd,
  output logic                          mem_wr,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          conflict_err
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   winner;
  logic [CNT_W-1:0]   lat_cnt;
  logic               op_wr;

  // Handshake: a core requests by holding rd or wr (with addr/wdata) high and
  // keeps everything stable until it sees its core_ack bit; it drops the
  // request at the edge that ends the ack cycle.
  logic [NUM_CORES-1:0] req;
  logic                 found;
  logic [IDX_W-1:0]     pick;

  assign req = core_rd | core_wr;

  // Search starts just past the previous winner so it gets lowest priority.
  always_comb begin
    int sum;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    pick  = '0;
    sum   = 0;
    idx   = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_CORES) sum = sum - NUM_CORES;
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= IDX_W'(NUM_CORES - 1);
      winner       <= '0;
      lat_cnt      <= '0;
      op_wr        <= 1'b0;
      core_ack     <= '0;
      core_rdata   <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      conflict_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            winner    <= pick;
            rr_ptr    <= pick;
            mem_addr  <= core_addr[pick*ADDR_W +: ADDR_W];
            mem_wdata <= core_wdata[pick*DATA_W +: DATA_W];
            // A core raising both rd and wr is served as a write.
            op_wr     <= core_wr[pick];
            mem_wr    <= core_wr[pick];
            mem_rd    <= ~core_wr[pick];
            if (core_rd[pick] && core_wr[pick]) conflict_err <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_rd  <= 1'b0;
          mem_wr  <= 1'b0;
          lat_cnt <= CNT_W'(MEM_LAT);
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == CNT_W'(1)) begin
            if (!op_wr) core_rdata <= mem_rdata;
            core_ack <= NUM_CORES'(1) << winner;
            lat_cnt  <= '0;
            state    <= ACK;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        ACK: begin
          core_ack <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/multicore_dmem_arbiter.md
Name: multicore_dmem_arbiter

Overview:
- Shared data-memory port for the multicore processor top.
- Accepts load/store requests from NUM_CORES cores and serialises them onto one data-memory port using round-robin arbitration.
- Returns read data and a one-cycle acknowledge to the granted core.
- Generalises the single-core direct memory connection to N cores, configurable widths and configurable memory latency.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- DATA_W, 16, data word width.
- ADDR_W, 16, data-memory address width.
- MEM_LAT, 1, cycles from the mem_rd/mem_wr strobe cycle to the mem_rdata-valid cycle (1..7).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- core_addr  input  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
- core_wdata  input  NUM_CORES*DATA_W  per-core write data, same packing.
- core_rd  input  NUM_CORES  per-core read request (level).
- core_wr  input  NUM_CORES  per-core write request (level).
- core_ack  output  NUM_CORES  one-hot, one-cycle completion pulse.
- core_rdata  output  DATA_W  read data, broadcast to all cores; valid in the core_ack cycle.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- mem_rdata  input  DATA_W  memory read data.
- conflict_err  output  1  sticky; set when a granted request has both rd and wr high.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; core_ack=0; core_rdata=0; mem_addr=0; mem_wdata=0; mem_rd=0; mem_wr=0; conflict_err=0; rr_ptr=NUM_CORES-1 (core 0 wins first); latency counter=0. Reset mid-transaction abandons it with no ack. Release is synchronous to the next rising edge.
- Request protocol: core i is requesting when core_rd[i]|core_wr[i]. The core holds addr/wdata/op stable until core_ack[i] and drops its request at the edge ending the ack cycle. A request seen in IDLE after that edge is a new request.
- All outputs are registered.
- FSM:
  - IDLE: if any request, grant the first requester searching from rr_ptr+1 modulo NUM_CORES. Latch mem_addr and mem_wdata from the winner. Set mem_wr if core_wr, else mem_rd. Set rr_ptr=winner. Go ISSUE. No request: stay in IDLE.
  - ISSUE (one cycle, strobe high): clear strobe; load counter=MEM_LAT; go WAIT.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, capture mem_rdata into core_rdata (read only; a write leaves core_rdata unchanged), set core_ack[winner]=1, and go ACK.
  - ACK (one cycle): clear core_ack; go IDLE.
- Timing, MEM_LAT=L:
  - Request first seen in cycle r → strobe in cycle r+1 → mem_rdata sampled in cycle r+1+L → ack in cycle r+2+L. L=1 gives ack at r+3.
  - Throughput is one transaction per L+3 cycles.
- Round-robin: the previous winner has lowest priority next arbitration. With all cores requesting continuously, grants go 0,1,2,...,N-1,0,...
- Requests arriving in any state other than IDLE wait; there is no preemption.
- rd and wr both high on the granted core: treated as a write; conflict_err set, cleared only by reset.
- Non-granted requests never see ack. Exactly one core_ack bit is high at a time.
- mem_addr and mem_wdata hold their last value when idle. mem_rd and mem_wr are never both high.

Test Plan:
- Single read: MEM_LAT=1, core0 rd addr 0x0010, memory returns 0xBEEF → mem_rd high only in r+1 with mem_addr=0x0010; core_ack=0001 in r+3; core_rdata=0xBEEF.
- Single write: core2 wr addr 0x0044 data 0x1234 → mem_wr pulse in r+1 with mem_addr=0x0044, mem_wdata=0x1234; core_ack=0100 in r+3; core_rdata unchanged.
- Contention: all 4 cores request continuously from reset → grant order 0,1,2,3,0; acks spaced 4 cycles apart; no double ack.
- Fairness after partial idle: core3 served, then cores 1 and 3 request together → core1 granted first.
- Conflict: core1 asserts rd and wr together → write issued, conflict_err=1 from the ISSUE cycle on, cleared only by rst_n.
- Reset mid-WAIT with MEM_LAT=3: assert rst_n=0 during WAIT → all outputs 0 immediately, no ack. After release, a held request is re-arbitrated with core 0 priority, ack at r+5.
